// File: rtl/cmd_pkg.sv
// Shared encodings for the host-command parser: FSM states, error codes, default opcodes.
// Pure declarations; no logic, no latency, no flow control.
package cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_OPCODE = 2'd2,
        ST_ARG    = 2'd3
    } st_t;

    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_INDEX   = 2'd3;

    localparam logic [7:0] DEF_REG_BASE   = 8'h10;
    localparam logic [7:0] DEF_RST_OPCODE = 8'hFF;

endpackage

// File: rtl/cmd_timeout.sv
// Inter-byte watchdog: counts idle enabled cycles, pulses expired at CYCLES-1 unless cleared.
// Expiry is combinational from the count; no backpressure.
module cmd_timeout #(
    parameter int unsigned CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    // A byte arriving in the expiry cycle beats the timeout.
    assign expired = en && !clr && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en || (cnt == LIMIT)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// Length-prefixed byte-stream parser: data frames out with first/last, command frames to soft reset or a register bank.
// All strobes registered one cycle after the causing rx_valid; accepts a byte every cycle, no backpressure.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS       = 2,
    parameter int unsigned REG_BYTES      = 1,
    parameter logic [7:0]  REG_BASE       = DEF_REG_BASE,
    parameter logic [7:0]  RST_OPCODE     = DEF_RST_OPCODE,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [31:0] REG_RESET      = '0,
    localparam int REG_W = 8 * REG_BYTES,
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                data_out,
    output logic                      data_valid,
    output logic                      data_first,
    output logic                      data_last,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic                      reg_wr,
    output logic [IDX_W-1:0]          reg_idx,
    output logic                      soft_rst,
    output logic                      err,
    output logic [1:0]                err_code,
    output logic                      busy
);

    localparam logic [2:0] LAST_BYTE = 3'(REG_BYTES - 1);

    st_t                      state, state_nx;
    logic [7:0]               remaining, remaining_nx;
    logic                     first_pend, first_pend_nx;
    logic [IDX_W-1:0]         idx, idx_nx;
    logic [REG_W-1:0]         shadow, shadow_nx, shifted;
    logic [2:0]               bcnt, bcnt_nx;
    logic [NUM_REGS*REG_W-1:0] regs_nx;
    logic [7:0]               data_out_nx;
    logic                     data_valid_nx, data_first_nx, data_last_nx;
    logic                     reg_wr_nx, soft_rst_nx, err_nx;
    logic [IDX_W-1:0]         reg_idx_nx;
    logic [1:0]               err_code_nx;
    logic                     tmo_expired;
    logic [7:0]               op_off;
    logic                     in_bank, idx_ok;

    cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_valid),
        .en      (state != ST_IDLE),
        .expired (tmo_expired)
    );

    // Bytes arrive MSB first, so each new byte enters at the bottom.
    if (REG_BYTES == 1) begin : g_shift1
        assign shifted = rx_data;
    end else begin : g_shiftn
        assign shifted = {shadow[REG_W-9:0], rx_data};
    end

    assign op_off  = rx_data - REG_BASE;
    assign in_bank = ({1'b0, rx_data} >= {1'b0, REG_BASE}) &&
                     ({1'b0, rx_data} <  ({1'b0, REG_BASE} + 9'd16));
    assign idx_ok  = ({24'd0, op_off} < NUM_REGS);
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nx      = state;
        remaining_nx  = remaining;
        first_pend_nx = first_pend;
        idx_nx        = idx;
        shadow_nx     = shadow;
        bcnt_nx       = bcnt;
        regs_nx       = regs;
        data_out_nx   = data_out;
        data_valid_nx = 1'b0;
        data_first_nx = 1'b0;
        data_last_nx  = 1'b0;
        reg_wr_nx     = 1'b0;
        reg_idx_nx    = reg_idx;
        soft_rst_nx   = 1'b0;
        err_nx        = 1'b0;
        err_code_nx   = err_code;

        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == 8'd0) begin
                        state_nx = ST_OPCODE;
                    end else begin
                        remaining_nx  = rx_data;
                        first_pend_nx = 1'b1;
                        state_nx      = ST_DATA;
                    end
                end
                ST_DATA: begin
                    data_out_nx   = rx_data;
                    data_valid_nx = 1'b1;
                    data_first_nx = first_pend;
                    first_pend_nx = 1'b0;
                    remaining_nx  = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        data_last_nx = 1'b1;
                        state_nx     = ST_IDLE;
                    end
                end
                ST_OPCODE: begin
                    state_nx = ST_IDLE;
                    if (rx_data == RST_OPCODE) begin
                        soft_rst_nx = 1'b1;
                    end else if (in_bank && idx_ok) begin
                        idx_nx    = op_off[IDX_W-1:0];
                        shadow_nx = '0;
                        bcnt_nx   = 3'd0;
                        state_nx  = ST_ARG;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = in_bank ? ERR_INDEX : ERR_OPCODE;
                    end
                end
                ST_ARG: begin
                    shadow_nx = shifted;
                    bcnt_nx   = bcnt + 3'd1;
                    if (bcnt == LAST_BYTE) begin
                        regs_nx[idx*REG_W +: REG_W] = shifted;
                        reg_wr_nx  = 1'b1;
                        reg_idx_nx = idx;
                        state_nx   = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end else if (tmo_expired) begin
            err_nx      = 1'b1;
            err_code_nx = ERR_TIMEOUT;
            state_nx    = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            remaining  <= 8'd0;
            first_pend <= 1'b0;
            idx        <= '0;
            shadow     <= '0;
            bcnt       <= 3'd0;
            regs       <= {NUM_REGS{REG_RESET[REG_W-1:0]}};
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            data_first <= 1'b0;
            data_last  <= 1'b0;
            reg_wr     <= 1'b0;
            reg_idx    <= '0;
            soft_rst   <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            first_pend <= first_pend_nx;
            idx        <= idx_nx;
            shadow     <= shadow_nx;
            bcnt       <= bcnt_nx;
            regs       <= regs_nx;
            data_out   <= data_out_nx;
            data_valid <= data_valid_nx;
            data_first <= data_first_nx;
            data_last  <= data_last_nx;
            reg_wr     <= reg_wr_nx;
            reg_idx    <= reg_idx_nx;
            soft_rst   <= soft_rst_nx;
            err        <= err_nx;
            err_code   <= err_code_nx;
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: byte-stream vector table plus timeout, wide-register and reset sequences.
module tb_cmd_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data1 = 8'd0;
    logic       rx_valid1 = 1'b0;

    logic [7:0]  data_out, data_out1;
    logic        data_valid, data_first, data_last;
    logic        data_valid1, data_first1, data_last1;
    logic [15:0] regs;
    logic [31:0] regs1;
    logic        reg_wr, reg_wr1, soft_rst, soft_rst1, err, err1, busy, busy1;
    logic [0:0]  reg_idx, reg_idx1;
    logic [1:0]  err_code, err_code1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmd_parser #(.NUM_REGS(2), .REG_BYTES(1), .REG_BASE(8'h10), .RST_OPCODE(8'hFF),
                 .TIMEOUT_CYCLES(50), .REG_RESET(32'h0)) u0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .data_out(data_out), .data_valid(data_valid), .data_first(data_first),
        .data_last(data_last), .regs(regs), .reg_wr(reg_wr), .reg_idx(reg_idx),
        .soft_rst(soft_rst), .err(err), .err_code(err_code), .busy(busy)
    );

    cmd_parser #(.NUM_REGS(2), .REG_BYTES(2), .REG_BASE(8'h10), .RST_OPCODE(8'hFF),
                 .TIMEOUT_CYCLES(50), .REG_RESET(32'h0)) u1 (
        .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .data_out(data_out1), .data_valid(data_valid1), .data_first(data_first1),
        .data_last(data_last1), .regs(regs1), .reg_wr(reg_wr1), .reg_idx(reg_idx1),
        .soft_rst(soft_rst1), .err(err1), .err_code(err_code1), .busy(busy1)
    );

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       dv, fst, lst;
        logic [7:0] dout;
        logic       wr;
        logic [0:0] idx;
        logic       srst, err;
        logic [1:0] code;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic vld, input logic [7:0] dat,
                               input logic dv, input logic fst, input logic lst,
                               input logic [7:0] dout, input logic wr, input logic [0:0] idx,
                               input logic srst, input logic e, input logic [1:0] code,
                               input logic bsy);
        vec_t r;
        r.vld = vld; r.dat = dat; r.dv = dv; r.fst = fst; r.lst = lst; r.dout = dout;
        r.wr = wr; r.idx = idx; r.srst = srst; r.err = e; r.code = code; r.busy = bsy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic vl, input logic [7:0] d);
        @(negedge clk);
        rx_valid = vl;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic step1(input logic [7:0] d);
        @(negedge clk);
        rx_valid1 = 1'b1;
        rx_data1  = d;
        @(posedge clk);
        #1;
        rx_valid1 = 1'b0;
    endtask

    initial begin
        logic [17:0] act, exp;
        int          got;
        logic [1:0]  code;
        logic        seen_last;
        vec_t        e;

        // Fields: vld dat | dv fst lst dout | wr idx | srst err code | busy
        vq.push_back(v(1, 8'h00, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'hFF, 0,0,0,8'h00, 0,0, 1,0,2'd0, 0));
        vq.push_back(v(1, 8'h05, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(0, 8'h00, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'hAA, 1,1,0,8'hAA, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h55, 1,0,0,8'h55, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h00, 1,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'hFF, 1,0,0,8'hFF, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'hF0, 1,0,1,8'hF0, 0,0, 0,0,2'd0, 0));
        vq.push_back(v(1, 8'h00, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h10, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'hAA, 0,0,0,8'h00, 1,0, 0,0,2'd0, 0));
        vq.push_back(v(1, 8'h00, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h11, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h55, 0,0,0,8'h00, 1,1, 0,0,2'd0, 0));
        vq.push_back(v(1, 8'h00, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h12, 0,0,0,8'h00, 0,0, 0,1,2'd3, 0));
        vq.push_back(v(1, 8'h00, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h42, 0,0,0,8'h00, 0,0, 0,1,2'd1, 0));
        vq.push_back(v(1, 8'h01, 0,0,0,8'h00, 0,0, 0,0,2'd0, 1));
        vq.push_back(v(1, 8'h7E, 1,1,1,8'h7E, 0,0, 0,0,2'd0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {data_valid, data_first, data_last, reg_wr, soft_rst, err, busy}, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_code", err_code, 0);
        chk("rst_regs", regs, 0);
        chk("rst_regs1", regs1, 0);
        @(negedge clk);
        rst = 1'b1;

        // Two-byte register: only the final byte commits.
        step1(8'h00);
        step1(8'h11);
        step1(8'h12);
        chk("wide_partial_wr", reg_wr1, 0);
        chk("wide_partial_regs", regs1, 0);
        step1(8'h34);
        chk("wide_wr", {reg_wr1, reg_idx1}, 2'b11);
        chk("wide_regs", regs1, 32'h1234_0000);

        for (int i = 0; i < vq.size(); i++) begin
            e = vq[i];
            step(e.vld, e.dat);
            act = {data_valid, data_first, data_last, e.dv ? data_out : 8'h00,
                   reg_wr, e.wr ? reg_idx : 1'b0, soft_rst, err, e.err ? err_code : 2'b00, busy};
            exp = {e.dv, e.fst, e.lst, e.dout, e.wr, e.idx, e.srst, e.err, e.code, e.busy};
            chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
            if (i == 1) chk("srst_regs", regs, 0);
        end
        chk("regs_after_writes", regs, 16'h55AA);

        // Inter-byte timeout inside a data frame.
        step(1, 8'h03);
        step(1, 8'h11);
        chk("tmo_first", {data_valid, data_first, data_last, data_out}, {3'b110, 8'h11});
        got = 0;
        code = 2'd0;
        seen_last = 1'b0;
        for (int k = 1; k <= 60 && got == 0; k++) begin
            @(posedge clk);
            #1;
            if (data_last) seen_last = 1'b1;
            if (err) begin
                got  = k;
                code = err_code;
            end
        end
        chk("tmo_cycles", got, 50);
        chk("tmo_code", code, 2);
        chk("tmo_no_last", seen_last, 0);
        chk("tmo_busy", busy, 0);
        step(1, 8'h00);
        step(1, 8'h10);
        step(1, 8'h5A);
        chk("tmo_recover_wr", {reg_wr, reg_idx}, 2'b10);
        chk("tmo_recover_regs", regs, 16'h555A);

        // Hardware reset in the middle of a register write.
        step(1, 8'h00);
        step(1, 8'h10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_regs", regs, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        step(1, 8'h02);
        chk("arst_len_busy", {busy, reg_wr, err}, 3'b100);
        step(1, 8'h01);
        chk("arst_d0", {data_valid, data_first, data_last, data_out}, {3'b110, 8'h01});
        step(1, 8'h02);
        chk("arst_d1", {data_valid, data_first, data_last, data_out, busy}, {3'b101, 8'h02, 1'b0});
        chk("arst_regs_kept", regs, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
